// File: rtl/data_sram_like_responder.sv
// Data-side sram-like responder: word-addressed on-chip RAM with an in-order
// response queue of up to DEPTH outstanding requests and a fixed minimum latency.
module data_sram_like_responder #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        stall
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    logic              ent_wr_q  [DEPTH];
    logic              ent_wr_d  [DEPTH];
    logic [31:0]       ent_rd_q  [DEPTH];
    logic [31:0]       ent_rd_d  [DEPTH];
    logic [LAT_W-1:0]  ent_cnt_q [DEPTH];
    logic [LAT_W-1:0]  ent_cnt_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              data_ok_q, data_ok_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [ADDR_W-1:0] idx;
    logic [3:0]        mask;
    logic              push;
    logic              pop;
    logic              unused_addr_hi;

    assign idx            = addr[ADDR_W+1:2];
    assign unused_addr_hi = ^addr[31:ADDR_W+2];
    assign addr_ok        = resetn && (count_q < DEPTH_C);
    assign push           = req && addr_ok;
    assign pop            = data_ok_q;
    assign data_ok        = data_ok_q;
    assign rdata          = rdata_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mask = '0;
        case (size)
            2'd0:    mask = 4'b0001 << addr[1:0];
            2'd1:    mask = addr[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (mask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Output registers are loaded from the post-edge queue state, so data_ok
    // lands exactly LATENCY cycles after accept; stall is sampled one edge early.
    always_comb begin
        ent_wr_d  = ent_wr_q;
        ent_rd_d  = ent_rd_q;
        ent_cnt_d = ent_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_cnt_q[i] != '0) ent_cnt_d[i] = ent_cnt_q[i] - LAT_W'(1);
        end
        if (push) begin
            ent_wr_d[wr_ptr_q]  = wr;
            ent_rd_d[wr_ptr_q]  = mem[idx];
            ent_cnt_d[wr_ptr_q] = CNT_INIT;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        data_ok_d = (count_d != '0) && (ent_cnt_d[rd_ptr_d] == '0) && !stall;
        rdata_d   = (data_ok_d && !ent_wr_d[rd_ptr_d]) ? ent_rd_d[rd_ptr_d] : rdata_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_wr_q[i]  <= 1'b0;
                ent_rd_q[i]  <= '0;
                ent_cnt_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ent_wr_q  <= ent_wr_d;
            ent_rd_q  <= ent_rd_d;
            ent_cnt_q <= ent_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Directed and model-checked bench for data_sram_like_responder (ADDR_W=12, DEPTH=2, LATENCY=2).
module tb_data_sram_like_responder;

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned LATENCY = 2;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic        req    = 1'b0;
    logic        wr     = 1'b0;
    logic [1:0]  size   = 2'd0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic        stall  = 1'b0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        w;
        logic [31:0] rd;
        int          acc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mdl [16];

    data_sram_like_responder #(
        .ADDR_W (12),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .addr   (addr),
        .wdata  (wdata),
        .addr_ok(addr_ok),
        .data_ok(data_ok),
        .rdata  (rdata),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        check("send_addr_ok", addr_ok, 1);
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        tick();
        req = 1'b0;
    endtask

    task automatic op_write(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        send(1'b1, s, a, d);
        check("wr_dok_early", data_ok, 0);
        tick();
        check("wr_dok", data_ok, 1);
        tick();
        check("wr_dok_pulse", data_ok, 0);
    endtask

    task automatic op_read(input logic [31:0] a, input logic [31:0] exp);
        send(1'b0, 2'd2, a, 32'h0);
        check("rd_dok_early", data_ok, 0);
        tick();
        check("rd_dok", data_ok, 1);
        check("rd_data", rdata, exp);
        tick();
        check("rd_dok_pulse", data_ok, 0);
        check("rd_hold", rdata, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] s, input logic [1:0] lo);
        logic [31:0] r;
        r = old;
        case (s)
            2'd0: r[8*lo +: 8] = d[8*lo +: 8];
            2'd1: if (lo[1]) r[31:16] = d[31:16]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    int          t;
    int          idx;
    int          exp_aok;
    int          exp_dok;
    logic        prev_stall;
    logic [31:0] last_rd;

    initial begin
        // reset
        #1 resetn = 1'b0;
        #2;
        check("rst_aok", addr_ok, 0);
        check("rst_dok", data_ok, 0);
        check("rst_rdata", rdata, 0);
        tick();
        tick();
        #2 resetn = 1'b1;
        tick();
        check("rel_aok", addr_ok, 1);
        check("rel_dok", data_ok, 0);

        // 1: word write then read
        op_write(2'd2, 32'h100, 32'hDEADBEEF);
        op_read(32'h100, 32'hDEADBEEF);

        // 2: byte and half lanes, address aliasing
        op_write(2'd2, 32'h100, 32'h11223344);
        op_write(2'd0, 32'h101, 32'h0000AA00);
        op_read(32'h100, 32'h1122AA44);
        op_write(2'd1, 32'h102, 32'hBEEF0000);
        op_read(32'h100, 32'hBEEFAA44);
        op_read(32'hFFFF_C100, 32'hBEEFAA44);
        op_write(2'd3, 32'h200, 32'h000000A1);
        op_write(2'd2, 32'h204, 32'h000000B2);
        op_write(2'd2, 32'h208, 32'h000000C3);

        // 3: three back-to-back reads with DEPTH=2
        check("t3_aok0", addr_ok, 1);
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h200;
        tick();
        check("t3_aok1", addr_ok, 1);
        check("t3_dok1", data_ok, 0);
        addr = 32'h204;
        tick();
        check("t3_aok_full", addr_ok, 0);
        check("t3_dok2", data_ok, 1);
        check("t3_rd2", rdata, 32'hA1);
        addr = 32'h208;
        tick();
        check("t3_aok3", addr_ok, 1);
        check("t3_dok3", data_ok, 1);
        check("t3_rd3", rdata, 32'hB2);
        tick();
        req = 1'b0;
        check("t3_dok4", data_ok, 0);
        tick();
        check("t3_dok5", data_ok, 1);
        check("t3_rd5", rdata, 32'hC3);
        tick();
        check("t3_dok6", data_ok, 0);

        // 4: stall with two outstanding reads
        stall = 1'b1;
        req = 1'b1; addr = 32'h200;
        tick();
        addr = 32'h204;
        tick();
        req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t4_stall_aok", addr_ok, 0);
            check("t4_stall_dok", data_ok, 0);
            tick();
        end
        stall = 1'b0;
        tick();
        check("t4_dok_a", data_ok, 1);
        check("t4_rd_a", rdata, 32'hA1);
        tick();
        check("t4_dok_b", data_ok, 1);
        check("t4_rd_b", rdata, 32'hB2);
        tick();
        check("t4_dok_end", data_ok, 0);
        check("t4_aok_end", addr_ok, 1);

        // 5: asynchronous reset with two outstanding
        req = 1'b1; addr = 32'h200;
        tick();
        addr = 32'h204;
        tick();
        req = 1'b0;
        check("t5_dok_pre", data_ok, 1);
        check("t5_rd_pre", rdata, 32'hA1);
        #2 resetn = 1'b0;
        #1;
        check("t5_rst_aok", addr_ok, 0);
        check("t5_rst_dok", data_ok, 0);
        check("t5_rst_rdata", rdata, 0);
        tick();
        tick();
        #2 resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_no_late_dok", data_ok, 0);
            check("t5_aok", addr_ok, 1);
        end
        op_read(32'h208, 32'hC3);
        op_read(32'h100, 32'hBEEFAA44);

        // 6: random traffic against a reference model over words 0..15
        for (int i = 0; i < 16; i++) begin
            mdl[i] = (i * 32'h01010101) ^ 32'hA5A5_0000;
            op_write(2'd2, i * 4, mdl[i]);
        end
        last_rd    = 32'hBEEFAA44;
        prev_stall = 1'b0;
        t          = 0;
        for (int i = 0; i < 3000; i++) begin
            exp_aok = (q.size() < DEPTH) ? 1 : 0;
            exp_dok = (q.size() > 0 && t >= q[0].acc + LATENCY && !prev_stall) ? 1 : 0;
            check("rnd_aok", addr_ok, exp_aok);
            check("rnd_dok", data_ok, exp_dok);
            if (exp_dok != 0) begin
                if (!q[0].w) last_rd = q[0].rd;
                void'(q.pop_front());
            end
            check("rnd_rdata", rdata, last_rd);
            req   = ($urandom_range(0, 9) < 7);
            wr    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            idx   = $urandom_range(0, 15);
            addr  = ($urandom & 32'hFFFF_C000) | (idx << 2) | $urandom_range(0, 3);
            wdata = $urandom;
            stall = ($urandom_range(0, 3) == 0);
            if (req && exp_aok != 0) begin
                q.push_back('{wr, mdl[idx], t});
                if (wr) mdl[idx] = merge(mdl[idx], wdata, size, addr[1:0]);
            end
            prev_stall = stall;
            tick();
            t++;
        end
        req   = 1'b0;
        stall = 1'b0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
